// File: rtl/nios_system_sysid_ext_if.sv
// ---------------------------------------------------------------------------
// nios_system_sysid_ext_if
// Avalon-MM slave bus bundle for the extended system-ID block.
//
// Signals:
//   address        master -> slave  ADDR_W  word address
//   read           master -> slave  1       read request (never stalled)
//   write          master -> slave  1       write request (never stalled)
//   writedata      master -> slave  32      write data
//   byteenable     master -> slave  4       byte lanes for writes
//   readdata       slave -> master  32      read data, qualified by readdatavalid
//   readdatavalid  slave -> master  1       one pulse per accepted read
//
// Modports: master (bus initiator), slave (the system-ID block).
// ---------------------------------------------------------------------------
interface nios_system_sysid_ext_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/nios_system_sysid_ext.sv
// ---------------------------------------------------------------------------
// nios_system_sysid_ext
// Avalon-MM system-ID slave: ID, build timestamp, capability word, 64-bit
// uptime counter with a coherent high-word snapshot, a byte-writable scratch
// register and NUM_USER_WORDS user-info words. Reads are answered through a
// READ_LATENCY-deep register pipeline; there is no waitrequest.
//
// Ports:
//   clock      in   1                   rising-edge system clock
//   reset_n    in   1                   asynchronous active-low reset
//   bus        slave modport            Avalon-MM address/read/write/data/valid
//   user_info  in   32*NUM_USER_WORDS   user word k in bits [32k+31:32k]
//
// Word map: 0 ID | 1 TIMESTAMP | 2 CAPS | 3 UPTIME_LO | 4 UPTIME_HI snapshot
//           | 5 SCRATCH | 6..5+N USER[k] | anything else reads 0.
// ---------------------------------------------------------------------------
module nios_system_sysid_ext #(
    parameter logic [31:0] ID_VALUE       = 32'h68F8_0A14,
    parameter logic [31:0] TIMESTAMP      = 32'd0,
    parameter int          NUM_USER_WORDS = 4,
    parameter int          READ_LATENCY   = 1,
    parameter int          ADDR_W         = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    nios_system_sysid_ext_if.slave       bus,
    input  logic [32*NUM_USER_WORDS-1:0] user_info
);

    localparam logic [ADDR_W-1:0] WORD_ID        = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] WORD_TIMESTAMP = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] WORD_CAPS      = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] WORD_UPTIME_LO = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_UPTIME_HI = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] WORD_SCRATCH   = ADDR_W'(5);
    localparam int                USER_BASE      = 6;

    localparam logic [31:0] CAPS_VALUE = {8'h01, 8'(ADDR_W), 8'(NUM_USER_WORDS), 8'(READ_LATENCY)};

    logic [63:0] r_uptime;
    logic [31:0] r_hiSnap;
    logic [31:0] r_scratch;
    logic [31:0] w_readSel;
    logic        w_wrUptime;
    logic        w_wrScratch;
    logic        w_rdUptimeLo;

    logic [READ_LATENCY-1:0] r_pipeValid;
    logic [31:0]             r_pipeData [READ_LATENCY];

    assign w_wrUptime   = bus.write && (bus.address == WORD_UPTIME_LO);
    assign w_wrScratch  = bus.write && (bus.address == WORD_SCRATCH);
    assign w_rdUptimeLo = bus.read  && (bus.address == WORD_UPTIME_LO);

    // Read data is picked from the current register values, so a read that
    // coincides with a write to the same word returns the pre-write contents.
    always_comb begin
        w_readSel = '0;
        case (bus.address)
            WORD_ID:        w_readSel = ID_VALUE;
            WORD_TIMESTAMP: w_readSel = TIMESTAMP;
            WORD_CAPS:      w_readSel = CAPS_VALUE;
            WORD_UPTIME_LO: w_readSel = r_uptime[31:0];
            WORD_UPTIME_HI: w_readSel = r_hiSnap;
            WORD_SCRATCH:   w_readSel = r_scratch;
            default: begin
                for (int k = 0; k < NUM_USER_WORDS; k++) begin
                    if (bus.address == ADDR_W'(USER_BASE + k)) begin
                        w_readSel = user_info[32*k +: 32];
                    end
                end
            end
        endcase
    end

    // Free-running uptime. Reading the low word captures the high word from
    // the same sample so software sees a tear-free 64-bit value when it reads
    // LO then HI. Writing the low word restarts the count from zero but
    // leaves the snapshot alone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_uptime <= '0;
            r_hiSnap <= '0;
        end else begin
            if (w_wrUptime) begin
                r_uptime <= '0;
            end else begin
                r_uptime <= r_uptime + 64'd1;
            end
            if (w_rdUptimeLo) begin
                r_hiSnap <= r_uptime[63:32];
            end
        end
    end

    // Scratch register with per-byte write enables.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_scratch <= '0;
        end else if (w_wrScratch) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteenable[b]) begin
                    r_scratch[8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline: a valid bit and a data word per stage. Data stages only
    // load when a valid word moves into them, so readdata holds the last
    // returned value between pulses. Reset empties every stage, which drops
    // any read still in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pipeValid <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                r_pipeData[s] <= '0;
            end
        end else begin
            r_pipeValid[0] <= bus.read;
            if (bus.read) begin
                r_pipeData[0] <= w_readSel;
            end
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_pipeValid[s] <= r_pipeValid[s-1];
                if (r_pipeValid[s-1]) begin
                    r_pipeData[s] <= r_pipeData[s-1];
                end
            end
        end
    end

    assign bus.readdata      = r_pipeData[READ_LATENCY-1];
    assign bus.readdatavalid = r_pipeValid[READ_LATENCY-1];

endmodule
